// File: rtl/uw_pkg.sv
// Shared types and constants for the unique-word QPSK transmit framer.
package uw_pkg;

    localparam int unsigned UW_LEN  = 16;
    localparam int unsigned UW_BITS = 32;

    typedef enum logic [1:0] {
        IDLE,
        UW,
        PAYLOAD
    } state_e;

    typedef enum logic [1:0] {
        ROT_0,
        ROT_90,
        ROT_180,
        ROT_270
    } rot_e;

    // Symbol n of the UW sits at bits [31-2n -: 2], so symbol 0 is the MSB pair.
    function automatic logic [1:0] uw_symbol(input logic [UW_BITS-1:0] pat, input logic [3:0] idx);
        logic [UW_BITS-1:0] sh;
        sh = pat << {idx, 1'b0};
        return sh[UW_BITS-1 -: 2];
    endfunction

endpackage

// File: rtl/qpsk_sym_mapper.sv
// Combinational QPSK mapper: {q_bit,i_bit} to +/-AMP per axis, then a k*90 degree rotation.
module qpsk_sym_mapper
    import uw_pkg::*;
#(
    parameter int unsigned         W   = 16,
    parameter logic signed [W-1:0] AMP = W'(8192)
) (
    input  logic [1:0]   sym_i,
    input  logic [1:0]   rot_i,
    output logic [W-1:0] i_o,
    output logic [W-1:0] q_o
);

    localparam logic [W-1:0] POS = AMP;
    localparam logic [W-1:0] NEG = -AMP;

    logic [W-1:0] base_i;
    logic [W-1:0] base_q;

    always_comb begin
        base_i = sym_i[0] ? POS : NEG;
        base_q = sym_i[1] ? POS : NEG;
        i_o    = base_i;
        q_o    = base_q;
        case (rot_e'(rot_i))
            ROT_0:   begin i_o = base_i;  q_o = base_q;  end
            ROT_90:  begin i_o = -base_q; q_o = base_i;  end
            ROT_180: begin i_o = -base_i; q_o = -base_q; end
            ROT_270: begin i_o = base_q;  q_o = -base_i; end
        endcase
    end

endmodule

// File: rtl/uw_frame_inserter.sv
// Transmit framer: 16-symbol UW preamble followed by PAYLOAD_LEN payload symbols,
// mapped to rotated QPSK I/Q behind a single ready/valid output register.
module uw_frame_inserter
    import uw_pkg::*;
#(
    parameter int unsigned          PAYLOAD_LEN = 64,
    parameter int unsigned          W           = 16,
    parameter logic signed [W-1:0]  AMP         = 16'sd8192
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  uw_pattern,
    input  logic [1:0]   tx_rot,
    input  logic [1:0]   pl_sym,
    input  logic         pl_valid,
    output logic         pl_ready,
    output logic [W-1:0] out_i,
    output logic [W-1:0] out_q,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_sof,
    output logic         out_eof,
    output logic         busy
);

    localparam int unsigned     PL_W    = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam logic [PL_W-1:0] PL_LAST = PL_W'(PAYLOAD_LEN - 1);
    localparam logic [3:0]      UW_LAST = 4'(UW_LEN - 1);

    state_e               state_q, state_d;
    logic [3:0]           uw_idx_q, uw_idx_d;
    logic [PL_W-1:0]      pl_idx_q, pl_idx_d;
    logic [UW_BITS-1:0]   pat_q, pat_d;
    logic [1:0]           rot_q, rot_d;
    logic [W-1:0]         out_i_q, out_i_d;
    logic [W-1:0]         out_q_q, out_q_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_sof_q, out_sof_d;
    logic                 out_eof_q, out_eof_d;

    logic                 ld_c;
    logic                 busy_c;
    logic                 load_c;
    logic                 sof_c;
    logic                 eof_c;
    logic                 pl_ready_c;
    logic [1:0]           map_sym_c;
    logic [1:0]           map_rot_c;
    logic [W-1:0]         map_i_c;
    logic [W-1:0]         map_q_c;

    qpsk_sym_mapper #(
        .W   (W),
        .AMP (AMP)
    ) u_mapper (
        .sym_i (map_sym_c),
        .rot_i (map_rot_c),
        .i_o   (map_i_c),
        .q_o   (map_q_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            uw_idx_q    <= '0;
            pl_idx_q    <= '0;
            pat_q       <= '0;
            rot_q       <= '0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            uw_idx_q    <= uw_idx_d;
            pl_idx_q    <= pl_idx_d;
            pat_q       <= pat_d;
            rot_q       <= rot_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
        end
    end

    // Symbol 0 is loaded in the start-accept cycle straight from the input pattern.
    always_comb begin
        ld_c        = !out_valid_q || out_ready;
        busy_c      = (state_q != IDLE) || out_valid_q;
        state_d     = state_q;
        uw_idx_d    = uw_idx_q;
        pl_idx_d    = pl_idx_q;
        pat_d       = pat_q;
        rot_d       = rot_q;
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;
        out_valid_d = out_valid_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        load_c      = 1'b0;
        sof_c       = 1'b0;
        eof_c       = 1'b0;
        pl_ready_c  = 1'b0;
        map_sym_c   = uw_symbol(pat_q, uw_idx_q);
        map_rot_c   = rot_q;

        case (state_q)
            IDLE: begin
                if (start && !busy_c) begin
                    pat_d     = uw_pattern;
                    rot_d     = tx_rot;
                    map_sym_c = uw_symbol(uw_pattern, 4'd0);
                    map_rot_c = tx_rot;
                    load_c    = 1'b1;
                    sof_c     = 1'b1;
                    uw_idx_d  = 4'd1;
                    state_d   = UW;
                end
            end
            UW: begin
                if (ld_c) begin
                    load_c   = 1'b1;
                    uw_idx_d = uw_idx_q + 4'd1;
                    if (uw_idx_q == UW_LAST) begin
                        uw_idx_d = '0;
                        state_d  = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                pl_ready_c = ld_c;
                map_sym_c  = pl_sym;
                if (ld_c && pl_valid) begin
                    load_c = 1'b1;
                    if (pl_idx_q == PL_LAST) begin
                        eof_c    = 1'b1;
                        pl_idx_d = '0;
                        state_d  = IDLE;
                    end else begin
                        pl_idx_d = pl_idx_q + PL_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A free output slot with nothing to load becomes a bubble.
        if (load_c) begin
            out_valid_d = 1'b1;
            out_i_d     = map_i_c;
            out_q_d     = map_q_c;
            out_sof_d   = sof_c;
            out_eof_d   = eof_c;
        end else if (ld_c) begin
            out_valid_d = 1'b0;
            out_sof_d   = 1'b0;
            out_eof_d   = 1'b0;
        end
    end

    assign pl_ready  = pl_ready_c;
    assign busy      = busy_c;
    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_uw_frame_inserter.sv
// Scoreboard bench for uw_frame_inserter: stimulus pushes expected samples, a negedge monitor checks them.
module tb_uw_frame_inserter;

    localparam int LEN = 64;
    localparam int AMP = 8192;

    typedef struct {
        int i;
        int q;
        bit sof;
        bit eof;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] uw_pattern = '0;
    logic [1:0]  tx_rot = '0;
    logic [1:0]  pl_sym = '0;
    logic        pl_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        pl_ready;
    logic [15:0] out_i;
    logic [15:0] out_q;
    logic        out_valid;
    logic        out_sof;
    logic        out_eof;
    logic        busy;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    bit   abort   = 1'b0;

    int   cyc = 0;
    int   acc_cnt = 0;
    int   gap_cnt = 0;
    int   last_gap = -1;
    int   sof_cnt = 0;
    int   last_eof_cyc = -1000;
    int   b2b_gap = -1;
    int   first_i = 0;
    int   first_q = 0;
    bit   in_frame = 1'b0;
    bit   stalled = 1'b0;
    logic [15:0] h_i, h_q;
    logic        h_sof, h_eof;
    exp_t        mon_e;

    uw_frame_inserter #(
        .PAYLOAD_LEN (LEN),
        .W           (16),
        .AMP         (16'sd8192)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .uw_pattern (uw_pattern),
        .tx_rot     (tx_rot),
        .pl_sym     (pl_sym),
        .pl_valid   (pl_valid),
        .pl_ready   (pl_ready),
        .out_i      (out_i),
        .out_q      (out_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    function automatic logic [1:0] sym_of(input int seed, input int k);
        int v;
        v = k * 5 + seed + k / 7;
        return v[1:0];
    endfunction

    function automatic void map_sym(input logic [1:0] s, input logic [1:0] r, output int i, output int q);
        int bi, bq;
        bi = s[0] ? AMP : -AMP;
        bq = s[1] ? AMP : -AMP;
        case (r)
            2'd0: begin i = bi;  q = bq;  end
            2'd1: begin i = -bq; q = bi;  end
            2'd2: begin i = -bi; q = -bq; end
            default: begin i = bq; q = -bi; end
        endcase
    endfunction

    task automatic push_frame(input logic [31:0] pat, input logic [1:0] r, input int seed, input int koff);
        exp_t e;
        logic [1:0] s;
        for (int n = 0; n < 16; n++) begin
            s = pat[31 - 2 * n -: 2];
            map_sym(s, r, e.i, e.q);
            e.sof = (n == 0);
            e.eof = 1'b0;
            exp_q.push_back(e);
        end
        for (int k = 0; k < LEN; k++) begin
            map_sym(sym_of(seed, koff + k), r, e.i, e.q);
            e.sof = 1'b0;
            e.eof = (k == LEN - 1);
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard monitor: pops on every accepted sample, checks stall hold and bubbles.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            stalled  = 1'b0;
            in_frame = 1'b0;
        end else begin
            if (stalled)
                chk(out_valid && out_i == h_i && out_q == h_q && out_sof == h_sof && out_eof == h_eof,
                    "hold_under_backpressure", int'($signed(out_i)), int'($signed(h_i)));
            if (out_valid && !out_ready)
                chk(!pl_ready, "pl_ready_during_stall", int'(pl_ready), 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_sample", int'($signed(out_i)), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    n_total++;
                    if ($signed(out_i) == mon_e.i && $signed(out_q) == mon_e.q &&
                        out_sof == mon_e.sof && out_eof == mon_e.eof) begin
                        n_pass++;
                    end else begin
                        $display("FAIL sample%0d: got i=%0d q=%0d sof=%0b eof=%0b expected i=%0d q=%0d sof=%0b eof=%0b",
                                 acc_cnt, $signed(out_i), $signed(out_q), out_sof, out_eof,
                                 mon_e.i, mon_e.q, mon_e.sof, mon_e.eof);
                    end
                end
                if (out_sof) begin
                    acc_cnt  = 1;
                    gap_cnt  = 0;
                    in_frame = 1'b1;
                    sof_cnt++;
                    b2b_gap  = cyc - last_eof_cyc;
                    first_i  = int'($signed(out_i));
                    first_q  = int'($signed(out_q));
                end else begin
                    acc_cnt++;
                end
                if (out_eof) begin
                    in_frame     = 1'b0;
                    last_gap     = gap_cnt;
                    last_eof_cyc = cyc;
                end
            end else if (in_frame && !out_valid) begin
                gap_cnt++;
            end
            stalled = out_valid && !out_ready;
            h_i   = out_i;
            h_q   = out_q;
            h_sof = out_sof;
            h_eof = out_eof;
        end
    end

    task automatic wait_plready(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (abort) return;
            @(negedge clk);
            if (pl_ready) begin
                ok = 1'b1;
                return;
            end
        end
        if (!abort) chk(1'b0, "pl_ready_timeout", 0, 1);
    endtask

    task automatic drive_payload(input int n, input int seed, input int bub_at, input int bub_len);
        bit ok;
        for (int k = 0; k < n; k++) begin
            if (abort) break;
            if (k == bub_at) begin
                pl_valid = 1'b0;
                for (int b = 0; b < bub_len; b++) begin
                    wait_plready(ok);
                    if (!ok) begin
                        pl_valid = 1'b0;
                        return;
                    end
                    @(posedge clk); #1;
                end
            end
            pl_valid = 1'b1;
            pl_sym   = sym_of(seed, k);
            wait_plready(ok);
            if (!ok) break;
            @(posedge clk); #1;
        end
        pl_valid = 1'b0;
    endtask

    task automatic start_frame(input logic [31:0] pat, input logic [1:0] r);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            ok = !busy;
        end
        if (!ok) chk(1'b0, "idle_timeout", int'(busy), 0);
        @(posedge clk); #1;
        start      = 1'b1;
        uw_pattern = pat;
        tx_rot     = r;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && !busy;
        end
        chk(ok, "frame_done", exp_q.size(), 0);
    endtask

    task automatic wait_present(input int target, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk); #1;
            if (out_valid && acc_cnt == target) begin
                ok = 1'b1;
                return;
            end
        end
        chk(1'b0, "present_timeout", acc_cnt, target);
    endtask

    task automatic stall_at(input int target);
        bit ok;
        wait_present(target, ok);
        if (ok) begin
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
        end
    endtask

    task automatic wait_sof(input int cnt);
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk); #1;
            if (sof_cnt >= cnt) return;
        end
        chk(1'b0, "sof_timeout", sof_cnt, cnt);
    endtask

    int fi[4] = '{-8192, -8192,  8192, 8192};
    int fq[4] = '{ 8192, -8192, -8192, 8192};

    initial begin
        int base;
        bit ok;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(!out_valid, "reset_out_valid", int'(out_valid), 0);
        chk(out_i == 16'd0 && out_q == 16'd0, "reset_iq", int'($signed(out_i)), 0);
        chk(!out_sof && !out_eof, "reset_sof_eof", int'({out_sof, out_eof}), 0);
        chk(!busy && !pl_ready, "reset_busy_plready", int'({busy, pl_ready}), 0);

        // Rotation 0..3, contiguous frames
        for (int r = 0; r < 4; r++) begin
            push_frame(32'hA5A50F0F, 2'(r), r, 0);
            start_frame(32'hA5A50F0F, 2'(r));
            drive_payload(LEN, r, -1, 0);
            wait_done();
            chk(first_i == fi[r], "first_i_rot", first_i, fi[r]);
            chk(first_q == fq[r], "first_q_rot", first_q, fq[r]);
            chk(last_gap == 0, "no_bubbles", last_gap, 0);
        end

        // Backpressure at UW symbol 7 and payload index 20
        push_frame(32'h1B1BE4E4, 2'd0, 7, 0);
        start_frame(32'h1B1BE4E4, 2'd0);
        fork
            drive_payload(LEN, 7, -1, 0);
            begin
                stall_at(7);
                stall_at(36);
            end
        join
        wait_done();
        chk(last_gap == 0, "stall_no_bubbles", last_gap, 0);

        // Payload underflow at index 10
        push_frame(32'hA5A50F0F, 2'd1, 9, 0);
        start_frame(32'hA5A50F0F, 2'd1);
        drive_payload(LEN, 9, 10, 3);
        wait_done();
        chk(last_gap == 3, "underflow_bubbles", last_gap, 3);

        // Back-to-back with start held high; second frame captures the new tx_rot
        base = sof_cnt;
        push_frame(32'hA5A50F0F, 2'd2, 11, 0);
        push_frame(32'hA5A50F0F, 2'd3, 11, LEN);
        @(posedge clk); #1;
        start      = 1'b1;
        uw_pattern = 32'hA5A50F0F;
        tx_rot     = 2'd2;
        fork
            drive_payload(2 * LEN, 11, -1, 0);
            begin
                wait_sof(base + 1);
                chk(first_i == 8192 && first_q == -8192, "b2b_frame1_first", first_i, 8192);
                tx_rot = 2'd3;
                wait_sof(base + 2);
                start = 1'b0;
            end
        join
        wait_done();
        chk(b2b_gap == 2, "b2b_sof_after_eof", b2b_gap, 2);
        chk(first_i == 8192 && first_q == 8192, "b2b_frame2_first", first_q, 8192);
        chk(sof_cnt == base + 2, "b2b_frame_count", sof_cnt - base, 2);

        // Reset mid-payload, then a fresh frame with a new pattern
        push_frame(32'hA5A50F0F, 2'd2, 5, 0);
        start_frame(32'hA5A50F0F, 2'd2);
        fork
            drive_payload(LEN, 5, -1, 0);
            begin
                wait_present(46, ok);
                rst   = 1'b1;
                abort = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                exp_q.delete();
            end
        join
        @(negedge clk);
        chk(!out_valid, "midreset_out_valid", int'(out_valid), 0);
        chk(!busy, "midreset_busy", int'(busy), 0);
        chk(!pl_ready, "midreset_pl_ready", int'(pl_ready), 0);
        abort = 1'b0;
        base  = sof_cnt;
        push_frame(32'h5A5AF0F0, 2'd1, 6, 0);
        start_frame(32'h5A5AF0F0, 2'd1);
        drive_payload(LEN, 6, -1, 0);
        wait_done();
        chk(first_i == 8192 && first_q == 8192, "post_reset_first", first_i, 8192);
        chk(sof_cnt == base + 1, "post_reset_sof", sof_cnt - base, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
